// File: rtl/comparator_pkg.sv
// Shared encodings for the serial magnitude comparator: FSM states and the
// one-hot {gt, eq, lt} result vector.
package comparator_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  // Result vector bit order is {gt, eq, lt}.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] GT       = 3'b100;
  localparam logic [2:0] EQ       = 3'b010;
  localparam logic [2:0] LT       = 3'b001;

  // Collapse a per-bit verdict into the one-hot result encoding.
  function automatic logic [2:0] encode_result(input logic bit_eq, input logic bit_gt);
    if (bit_eq)      return EQ;
    else if (bit_gt) return GT;
    else             return LT;
  endfunction

endpackage

// File: rtl/comparator_1bit_dataflow.sv
// Single-bit magnitude comparator, pure dataflow. Treats both bits as
// unsigned; any sign-bit inversion is the caller's concern.
module comparator_1bit_dataflow (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic eq,
  output logic lt
);

  assign gt = a & ~b;
  assign lt = ~a & b;
  assign eq = ~(a ^ b);

endmodule

// File: rtl/comparator_nbit_serial.sv
// Bit-serial N-bit comparator: walks the operands MSB first, one bit pair per
// cycle, and stops at the first differing bit (or at bit 0 when all match).
module comparator_nbit_serial
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic             sm_q,    sm_d;
  logic [2:0]       res_q,   res_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic raw_gt, raw_eq, raw_lt;
  logic sign_swap;
  logic bit_gt;

  comparator_1bit_dataflow u_bit_cmp (
    .a  (a_q[idx_q]),
    .b  (b_q[idx_q]),
    .gt (raw_gt),
    .eq (raw_eq),
    .lt (raw_lt)
  );

  // In two's complement a set sign bit means "smaller", so the MSB verdict flips.
  assign sign_swap = sm_q && (idx_q == MSB_IDX);
  assign bit_gt    = sign_swap ? raw_lt : raw_gt;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sm_d    = sm_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sm_d    = signed_mode;
          idx_d   = MSB_IDX;
          res_d   = RES_NONE;
          busy_d  = 1'b1;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (!raw_eq || idx_q == '0) begin
          res_d   = encode_result(raw_eq, bit_gt);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      res_q   <= RES_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sm_q    <= sm_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = res_q[2];
  assign eq   = res_q[1];
  assign lt   = res_q[0];

endmodule

// File: tb/tb_comparator_nbit_serial.sv
// Directed bench for comparator_nbit_serial (WIDTH=8): latency, result,
// ignored start, back-to-back start and mid-operation reset.
module tb_comparator_nbit_serial;

  localparam int WIDTH = 8;
  localparam int BOUND = 40;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy, done, gt, eq, lt;

  int passed = 0;
  int total  = 0;

  comparator_nbit_serial #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .gt          (gt),
    .eq          (eq),
    .lt          (lt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Caller sits at a negedge; drives the request, lets the next posedge accept
  // it, then scrambles the inputs so late changes would corrupt the result.
  task automatic launch(input logic [7:0] va, input logic [7:0] vb, input logic sm);
    start       = 1'b1;
    a           = va;
    b           = vb;
    signed_mode = sm;
    @(posedge clk);
    #1;
    start       = 1'b0;
    a           = ~va;
    b           = va;
    signed_mode = ~sm;
  endtask

  // Counts cycles from the accept edge to done. inject_at > 0 fires a
  // conflicting start request while busy, which must be ignored.
  task automatic wait_done(input string tag, input int inject_at, output int n);
    @(negedge clk);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_res_clr"}, {29'd0, gt, eq, lt}, 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == inject_at) begin
        start = 1'b1;
        a     = 8'h00;
        b     = 8'hFF;
      end else begin
        start = 1'b0;
      end
    end while (!done && n < BOUND);
    start = 1'b0;
  endtask

  task automatic run(input string tag, input logic [7:0] va, input logic [7:0] vb,
                     input logic sm, input logic [2:0] exp_res, input int exp_lat,
                     input int inject_at);
    int n;
    launch(va, vb, sm);
    wait_done(tag, inject_at, n);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_res"}, {29'd0, gt, eq, lt}, {29'd0, exp_res});
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    a           = '0;
    b           = '0;
    #12;
    check("rst_outs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // {gt,eq,lt}: 100 = gt, 010 = eq, 001 = lt
    run("u_a5_a5",   8'hA5, 8'hA5, 1'b0, 3'b010, 8, 0);
    run("u_80_7f",   8'h80, 8'h7F, 1'b0, 3'b100, 1, 0);
    run("s_80_7f",   8'h80, 8'h7F, 1'b1, 3'b001, 1, 0);
    run("s_7f_80",   8'h7F, 8'h80, 1'b1, 3'b100, 1, 0);
    run("u_12_13",   8'h12, 8'h13, 1'b0, 3'b001, 8, 0);
    run("s_fe_ff",   8'hFE, 8'hFF, 1'b1, 3'b001, 8, 0);
    run("u_10_08",   8'h10, 8'h08, 1'b0, 3'b100, 4, 0);
    run("s_f0_f8",   8'hF0, 8'hF8, 1'b1, 3'b001, 5, 0);
    run("s_05_05",   8'h05, 8'h05, 1'b1, 3'b010, 8, 0);

    // Result holds and done drops after the pulse.
    @(negedge clk);
    check("pulse_drop", {31'd0, done}, 32'd0);
    check("res_hold", {29'd0, gt, eq, lt}, 32'b010);

    // Start while busy is ignored.
    run("ign_40_40", 8'h40, 8'h40, 1'b0, 3'b010, 8, 2);

    // Start in the done cycle is accepted with no gap.
    run("b2b_first", 8'h33, 8'h31, 1'b0, 3'b100, 7, 0);
    run("b2b_01_00", 8'h01, 8'h00, 1'b0, 3'b100, 8, 0);

    // Reset during cycle 3 of a compare aborts it with no done.
    @(negedge clk);
    launch(8'h33, 8'h33, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_no_done", {31'd0, done}, 32'd0);
    end
    // Start presented as reset releases: accepted on the first rising edge.
    start       = 1'b1;
    a           = 8'h81;
    b           = 8'h01;
    signed_mode = 1'b0;
    rst_n       = 1'b1;
    begin
      int n;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = 8'h00;
      b     = 8'hFF;
      wait_done("post_rst", 0, n);
      check("post_rst_lat", n, 1);
      check("post_rst_res", {29'd0, gt, eq, lt}, 32'b100);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
